// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM <-> bus DMA engine.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    BEGIN,
    TRANSFER,
    END,
    DONE,
    ERROR
  } dma_state_t;

  // Bus is byte addressed, RAM is word addressed: one word = 4 bus bytes.
  localparam logic [31:0] BUS_ADDR_INC = 32'd4;

endpackage

// File: rtl/dma_skid_buffer.sv
// Two-slot output stage for RAM->bus: an output register plus one skid entry
// that catches the word already in flight from the RAM when the bus stalls.
module dma_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         popReady,
  output logic         outValid,
  output logic [W-1:0] outData,
  output logic [1:0]   count
);

  logic         skValid;
  logic [W-1:0] skData;
  logic         pop;

  assign pop   = outValid & popReady;
  assign count = {1'b0, outValid} + {1'b0, skValid};

  // Refill the output slot from the skid entry first, so word order is kept.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      outValid <= 1'b0;
      outData  <= '0;
      skValid  <= 1'b0;
      skData   <= '0;
    end else if (clear) begin
      outValid <= 1'b0;
      outData  <= '0;
      skValid  <= 1'b0;
      skData   <= '0;
    end else if (!outValid || pop) begin
      if (skValid) begin
        outData  <= skData;
        outValid <= 1'b1;
        skValid  <= push;
        if (push) skData <= pushData;
      end else if (push) begin
        outData  <= pushData;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end else if (push) begin
      skData  <= pushData;
      skValid <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_dma_engine.sv
// Block DMA between a synchronous RAM port and a burst bus master interface.
// Splits a block into bursts of at most burstSize+1 words; bus->RAM writes
// each received word one cycle later, RAM->bus prefetches through a skid stage.
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int ramAddrBits = 9,
  parameter int dataWidth   = 32
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   start,
  input  logic                   direction,
  input  logic [31:0]            busStartAddress,
  input  logic [ramAddrBits-1:0] ramStartAddress,
  input  logic [9:0]             blockSize,
  input  logic [7:0]             burstSize,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ramAddrBits-1:0] ramAddress,
  output logic                   ramWriteEnable,
  output logic [dataWidth-1:0]   ramDataOut,
  input  logic [dataWidth-1:0]   ramDataIn,
  output logic                   requestBus,
  input  logic                   busGrant,
  output logic                   beginTransactionOut,
  output logic [31:0]            addressDataOut,
  output logic [7:0]             burstSizeOut,
  output logic                   readNotWriteOut,
  output logic                   dataValidOut,
  output logic                   endTransactionOut,
  input  logic [31:0]            addressDataIn,
  input  logic                   dataValidIn,
  input  logic                   busyIn,
  input  logic                   endTransactionIn,
  input  logic                   errorIn
);

  dma_state_t             state, nextState;
  logic                   cfgDir;
  logic [7:0]             cfgBurst;
  logic [31:0]            busAddr;
  logic [ramAddrBits-1:0] ramPtr, ramWrAddr;
  logic [9:0]             remaining, sendLeft, rdLeft, burstPlus1, burstWords;
  logic                   rdPending, rdIssue, endSeen, errReg;
  logic                   ramWeReg;
  logic [dataWidth-1:0]   ramDataReg;
  logic                   sbValid, sbClear, pop, wordXfer, onBus;
  logic [dataWidth-1:0]   sbData;
  logic [1:0]             sbCount;

  assign burstPlus1 = {2'b00, cfgBurst} + 10'd1;
  assign burstWords = (burstPlus1 < remaining) ? burstPlus1 : remaining;
  assign onBus      = (state == BEGIN) || (state == TRANSFER) || (state == END);

  // RAM->bus: issue a read only if the skid stage can still absorb it next cycle.
  assign sbClear  = !((state == BEGIN) || (state == TRANSFER));
  assign pop      = cfgDir && (state == TRANSFER) && sbValid && !busyIn;
  assign rdIssue  = cfgDir && !sbClear && (rdLeft != 10'd0) &&
                    (({1'b0, sbCount} + {2'b00, rdPending}) - {2'b00, pop} < 3'd2);
  assign wordXfer = (state == TRANSFER) && !errorIn && (cfgDir ? pop : dataValidIn);

  assign ramAddress     = cfgDir ? ramPtr : ramWrAddr;
  assign ramWriteEnable = ramWeReg;
  assign ramDataOut     = ramDataReg;
  assign error          = errReg;
  assign busy           = (state != IDLE);

  dma_skid_buffer #(.W(dataWidth)) u_skid (
    .clock    (clock),
    .nReset   (nReset),
    .clear    (sbClear),
    .push     (rdPending),
    .pushData (ramDataIn),
    .popReady (cfgDir && (state == TRANSFER) && !busyIn),
    .outValid (sbValid),
    .outData  (sbData),
    .count    (sbCount)
  );

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  // Next state and bus-side outputs; all bus outputs stay 0 off the bus.
  always_comb begin
    nextState           = state;
    done                = 1'b0;
    requestBus          = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = 32'd0;
    burstSizeOut        = 8'd0;
    readNotWriteOut     = 1'b0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    case (state)
      IDLE:     if (start) nextState = (blockSize == 10'd0) ? DONE : REQUEST;
      REQUEST: begin
        requestBus = 1'b1;
        if (busGrant) nextState = BEGIN;
      end
      BEGIN: begin
        requestBus          = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = busAddr;
        burstSizeOut        = 8'(sendLeft - 10'd1);
        readNotWriteOut     = ~cfgDir;
        nextState           = TRANSFER;
      end
      TRANSFER: begin
        requestBus = 1'b1;
        if (cfgDir && sbValid) begin
          dataValidOut   = 1'b1;
          addressDataOut = 32'(sbData);
        end
        if (wordXfer && (sendLeft == 10'd1)) nextState = END;
      end
      END: begin
        // Request released while the transaction closes so the arbiter sees a gap.
        endTransactionOut = cfgDir;
        if (cfgDir || endTransactionIn || endSeen)
          nextState = (remaining != 10'd0) ? REQUEST : DONE;
      end
      DONE:     begin done = 1'b1; nextState = IDLE; end
      ERROR:    begin done = 1'b1; nextState = IDLE; end
      default:  nextState = IDLE;
    endcase
    if (onBus && errorIn) nextState = ERROR;
  end

  // Configuration capture, address/word counters and the registered RAM write.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cfgDir     <= 1'b0;
      cfgBurst   <= '0;
      busAddr    <= '0;
      ramPtr     <= '0;
      ramWrAddr  <= '0;
      remaining  <= '0;
      sendLeft   <= '0;
      rdLeft     <= '0;
      rdPending  <= 1'b0;
      endSeen    <= 1'b0;
      errReg     <= 1'b0;
      ramWeReg   <= 1'b0;
      ramDataReg <= '0;
    end else begin
      ramWeReg  <= 1'b0;
      rdPending <= rdIssue;
      if (state == IDLE && start) begin
        cfgDir    <= direction;
        cfgBurst  <= burstSize;
        busAddr   <= busStartAddress;
        ramPtr    <= ramStartAddress;
        remaining <= blockSize;
        errReg    <= 1'b0;
      end
      if (state == REQUEST && busGrant) begin
        sendLeft <= burstWords;
        rdLeft   <= burstWords;
        endSeen  <= 1'b0;
      end
      if (rdIssue) begin
        ramPtr <= ramPtr + 1'b1;
        rdLeft <= rdLeft - 10'd1;
      end
      if (wordXfer) begin
        busAddr   <= busAddr + BUS_ADDR_INC;
        remaining <= remaining - 10'd1;
        sendLeft  <= sendLeft - 10'd1;
        if (!cfgDir) begin
          ramWeReg   <= 1'b1;
          ramWrAddr  <= ramPtr;
          ramDataReg <= dataWidth'(addressDataIn);
          ramPtr     <= ramPtr + 1'b1;
        end
      end
      // The slave may close the transaction together with its last word.
      if (state == TRANSFER && !cfgDir && endTransactionIn) endSeen <= 1'b1;
      if (onBus && errorIn) errReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine: bus->RAM bursts with RAM wrap, RAM->bus
// with and without back-pressure, bus error, zero-length block, ignored start
// and asynchronous reset mid-burst.
module tb_ram_dma_engine;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0, direction = 1'b0;
  logic [31:0] busStartAddress = '0;
  logic [8:0]  ramStartAddress = '0;
  logic [9:0]  blockSize = '0;
  logic [7:0]  burstSize = '0;
  logic        busy, done, error;
  logic [8:0]  ramAddress;
  logic        ramWriteEnable;
  logic [31:0] ramDataOut;
  logic [31:0] ramDataIn;
  logic        requestBus, busGrant = 1'b0;
  logic        beginTransactionOut, readNotWriteOut, dataValidOut, endTransactionOut;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn = '0;
  logic        dataValidIn = 1'b0, busyIn = 1'b0, endTransactionIn = 1'b0, errorIn = 1'b0;

  int          nCmp = 0, nBad = 0;
  int          doneCount = 0;
  int          endCnt;
  logic [31:0] mem [0:511];
  logic [8:0]  wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  logic [31:0] gotQ [$];

  ram_dma_engine dut (
    .clock(clock), .nReset(nReset), .start(start), .direction(direction),
    .busStartAddress(busStartAddress), .ramStartAddress(ramStartAddress),
    .blockSize(blockSize), .burstSize(burstSize),
    .busy(busy), .done(done), .error(error),
    .ramAddress(ramAddress), .ramWriteEnable(ramWriteEnable),
    .ramDataOut(ramDataOut), .ramDataIn(ramDataIn),
    .requestBus(requestBus), .busGrant(busGrant),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
    .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
    .endTransactionIn(endTransactionIn), .errorIn(errorIn)
  );

  always #5 clock = ~clock;

  // RAM model: registered read, write logged for checking.
  always @(posedge clock) begin
    ramDataIn <= mem[ramAddress];
    if (ramWriteEnable) begin
      mem[ramAddress] = ramDataOut;
      wrAddrQ.push_back(ramAddress);
      wrDataQ.push_back(ramDataOut);
    end
  end

  // Count done pulses seen at clock edges.
  always @(posedge clock) if (done) doneCount <= doneCount + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: timeout got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic startXfer(input logic dir, input logic [31:0] ba, input logic [8:0] ra,
                           input logic [9:0] bs, input logic [7:0] bu);
    direction = dir; busStartAddress = ba; ramStartAddress = ra;
    blockSize = bs; burstSize = bu; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for requestBus, grant for one cycle; returns in the BEGIN cycle.
  task automatic grantBus(input string tag);
    int n = 0;
    while (!requestBus && n < 20) begin step(); n++; end
    chk({tag, "_req"}, 32'(requestBus), 32'd1);
    busGrant = 1'b1;
    step();
    busGrant = 1'b0;
  endtask

  // Accept RAM->bus words until done; optionally stall 3 cycles once stallAt words arrived.
  task automatic collect(input int stallAt, input logic [31:0] holdExp);
    int stall = (stallAt >= 0) ? 3 : 0;
    gotQ.delete();
    endCnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) break;
      busyIn = 1'b0;
      if (gotQ.size() == stallAt && stall > 0) begin
        busyIn = 1'b1;
        stall--;
        chk("hold_vld", 32'(dataValidOut), 32'd1);
        chk("hold_data", addressDataOut, holdExp);
      end
      if (dataValidOut && !busyIn) gotQ.push_back(addressDataOut);
      if (endTransactionOut) endCnt++;
      step();
    end
    busyIn = 1'b0;
    chk("collect_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [8:0] t1Addr [8];
    int d0;
    t1Addr = '{9'h1FE, 9'h1FF, 9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;

    // ---- reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_req", 32'(requestBus), 32'd0);
    chk("rst_we", 32'(ramWriteEnable), 32'd0);
    nReset = 1'b1;
    step();

    // ---- bus->RAM, 8 words in two 4-word bursts, RAM address wraps
    wrAddrQ.delete(); wrDataQ.delete(); d0 = doneCount;
    startXfer(1'b0, 32'h1000, 9'h1FE, 10'd8, 8'd3);
    for (int b = 0; b < 2; b++) begin
      grantBus("t1");
      chk("t1_begin", 32'(beginTransactionOut), 32'd1);
      chk("t1_addr", addressDataOut, 32'h1000 + 32'(b) * 32'h10);
      chk("t1_bsz", 32'(burstSizeOut), 32'd3);
      chk("t1_rnw", 32'(readNotWriteOut), 32'd1);
      step();
      for (int w = 0; w < 4; w++) begin
        dataValidIn = 1'b1; addressDataIn = 32'hA000_0000 + 32'(b * 4 + w);
        step();
      end
      dataValidIn = 1'b0; endTransactionIn = 1'b1;
      step();
      endTransactionIn = 1'b0;
    end
    chk("t1_done", 32'(done), 32'd1);
    step(); step();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ndone", 32'(doneCount - d0), 32'd1);
    chk("t1_nwr", 32'(wrAddrQ.size()), 32'd8);
    for (int i = 0; i < 8 && i < wrAddrQ.size(); i++) begin
      chk("t1_wa", 32'(wrAddrQ[i]), 32'(t1Addr[i]));
      chk("t1_wd", wrDataQ[i], 32'hA000_0000 + 32'(i));
    end

    // ---- RAM->bus, 5 words, burstSize 255 -> one burst of 5
    for (int k = 0; k < 5; k++) mem[9'h010 + k] = 32'hB000_0000 + 32'(k);
    d0 = doneCount;
    startXfer(1'b1, 32'h2000, 9'h010, 10'd5, 8'd255);
    grantBus("t2");
    chk("t2_begin", 32'(beginTransactionOut), 32'd1);
    chk("t2_addr", addressDataOut, 32'h2000);
    chk("t2_bsz", 32'(burstSizeOut), 32'd4);
    chk("t2_rnw", 32'(readNotWriteOut), 32'd0);
    collect(-1, 32'h0);
    chk("t2_nw", 32'(gotQ.size()), 32'd5);
    for (int i = 0; i < 5 && i < gotQ.size(); i++) chk("t2_w", gotQ[i], 32'hB000_0000 + 32'(i));
    chk("t2_end", 32'(endCnt), 32'd1);
    step();
    chk("t2_ndone", 32'(doneCount - d0), 32'd1);

    // ---- RAM->bus with a 3-cycle stall after word 2, RAM wrap 0x1FF->0x000
    mem[9'h1FF] = 32'hC000_0000;
    for (int k = 1; k < 5; k++) mem[k - 1] = 32'hC000_0000 + 32'(k);
    startXfer(1'b1, 32'h2400, 9'h1FF, 10'd5, 8'd7);
    grantBus("t3");
    chk("t3_bsz", 32'(burstSizeOut), 32'd4);
    collect(2, 32'hC000_0002);
    chk("t3_nw", 32'(gotQ.size()), 32'd5);
    for (int i = 0; i < 5 && i < gotQ.size(); i++) chk("t3_w", gotQ[i], 32'hC000_0000 + 32'(i));
    chk("t3_end", 32'(endCnt), 32'd1);
    step();

    // ---- bus error on the third word of a bus->RAM burst
    wrAddrQ.delete(); wrDataQ.delete();
    startXfer(1'b0, 32'h3000, 9'h040, 10'd8, 8'd7);
    grantBus("t4");
    step();
    dataValidIn = 1'b1; addressDataIn = 32'hE000_0000; step();
    addressDataIn = 32'hE000_0001; step();
    addressDataIn = 32'hE000_0002; errorIn = 1'b1; step();
    dataValidIn = 1'b0; errorIn = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_err", 32'(error), 32'd1);
    chk("t4_req", 32'(requestBus), 32'd0);
    step();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sticky", 32'(error), 32'd1);
    step();
    chk("t4_nwr", 32'(wrAddrQ.size()), 32'd2);

    // ---- zero-length block: done next cycle, error cleared, no request
    startXfer(1'b0, 32'h0, 9'h0, 10'd0, 8'd0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_errclr", 32'(error), 32'd0);
    chk("t5_req", 32'(requestBus), 32'd0);
    step();
    chk("t5_idle", 32'(busy), 32'd0);

    // ---- start while busy ignored; config captured at the accepted start
    mem[9'h020] = 32'hD00D_0001;
    d0 = doneCount;
    startXfer(1'b1, 32'h4000, 9'h020, 10'd1, 8'd0);
    direction = 1'b0; busStartAddress = 32'hFFFF_0000; ramStartAddress = 9'h030;
    blockSize = 10'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_nodone", 32'(done), 32'd0);
    grantBus("t6");
    chk("t6_addr", addressDataOut, 32'h4000);
    chk("t6_rnw", 32'(readNotWriteOut), 32'd0);
    collect(-1, 32'h0);
    chk("t6_nw", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() > 0) chk("t6_w", gotQ[0], 32'hD00D_0001);
    step();
    chk("t6_ndone", 32'(doneCount - d0), 32'd1);

    // ---- asynchronous reset mid-burst
    wrAddrQ.delete(); wrDataQ.delete();
    startXfer(1'b0, 32'h5000, 9'h080, 10'd8, 8'd7);
    grantBus("t7");
    step();
    dataValidIn = 1'b1; addressDataIn = 32'hF000_0000; step();
    addressDataIn = 32'hF000_0001; step();
    dataValidIn = 1'b0;
    d0 = doneCount;
    #2 nReset = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_req", 32'(requestBus), 32'd0);
    chk("t7_we", 32'(ramWriteEnable), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_dv", 32'(dataValidOut), 32'd0);
    chk("t7_ad", addressDataOut, 32'd0);
    chk("t7_ra", 32'(ramAddress), 32'd0);
    chk("t7_rd", ramDataOut, 32'd0);
    step();
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t7_ndone", 32'(doneCount - d0), 32'd0);
    chk("t7_nwr", 32'(wrAddrQ.size()), 32'd1);
    chk("t7_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
